// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants, FSM encoding and hold-register layout for the writeback port arbiter.
package wb_port_arbiter_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;

  localparam logic RstEnable    = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [RegAddrBus-1:0] ZeroReg  = '0;
  localparam logic [RegBus-1:0]     ZeroWord = '0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REPLAY = 1'b1
  } arb_state_e;

  // Pipeline write parked while the MC result takes the port
  typedef struct packed {
    logic [RegAddrBus-1:0] addr;
    logic [RegBus-1:0]     data;
  } wb_hold_t;

endpackage

// File: rtl/wb_port_arbiter.sv
// Single regfile write port shared by the MEM/WB pipeline and a multi-cycle unit.
// The pipeline wins by default; a starved MC result forces a grant, and the
// displaced pipeline write is replayed one cycle later behind a stall bubble.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [RegAddrBus-1:0] reg_waddr_i,
  input  logic                  reg_we_i,
  input  logic [RegBus-1:0]     reg_wdata_i,
  input  logic                  mc_valid_i,
  input  logic [RegAddrBus-1:0] mc_waddr_i,
  input  logic [RegBus-1:0]     mc_wdata_i,
  output logic                  mc_ready_o,
  output logic                  stall_o,
  output logic [RegAddrBus-1:0] reg_waddr_o,
  output logic                  reg_we_o,
  output logic [RegBus-1:0]     reg_wdata_o
);

  localparam int unsigned CntBits = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned CntW    = (CntBits > 3) ? CntBits : 3;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  arb_state_e            state_q;
  logic [CntW-1:0]       starve_q;
  logic [CntW-1:0]       starve_d;
  wb_hold_t              hold_q;
  logic [RegAddrBus-1:0] reg_waddr_q;
  logic                  reg_we_q;
  logic [RegBus-1:0]     reg_wdata_q;

  logic in_rst;
  logic pipe_wr;
  logic mc_wr;
  logic starved;
  logic mc_grant;
  logic force_grant;

  // Grant decision for the current cycle; handshakes are suppressed in reset
  always_comb begin
    in_rst      = (rst_i == RstEnable);
    pipe_wr     = (reg_we_i == WriteEnable) && (reg_waddr_i != ZeroReg);
    mc_wr       = mc_valid_i;
    starved     = (starve_q == StarveMax);
    mc_grant    = !in_rst && (state_q == ST_IDLE) && mc_wr && (!pipe_wr || starved);
    force_grant = mc_grant && pipe_wr;
  end

  // Consecutive cycles an MC result has waited, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (!mc_wr || mc_grant) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  // Arbitration FSM with registered regfile write outputs
  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      hold_q      <= '0;
      reg_waddr_q <= ZeroReg;
      reg_we_q    <= WriteDisable;
      reg_wdata_q <= ZeroWord;
    end else begin
      starve_q <= starve_d;
      case (state_q)
        ST_IDLE: begin
          if (mc_grant) begin
            reg_waddr_q <= mc_waddr_i;
            reg_we_q    <= (mc_waddr_i != ZeroReg) ? WriteEnable : WriteDisable;
            reg_wdata_q <= mc_wdata_i;
            if (force_grant) begin
              hold_q  <= '{addr: reg_waddr_i, data: reg_wdata_i};
              state_q <= ST_REPLAY;
            end
          end else if (pipe_wr) begin
            reg_waddr_q <= reg_waddr_i;
            reg_we_q    <= WriteEnable;
            reg_wdata_q <= reg_wdata_i;
          end else begin
            reg_waddr_q <= ZeroReg;
            reg_we_q    <= WriteDisable;
            reg_wdata_q <= ZeroWord;
          end
        end
        ST_REPLAY: begin
          reg_waddr_q <= hold_q.addr;
          reg_we_q    <= (hold_q.addr != ZeroReg) ? WriteEnable : WriteDisable;
          reg_wdata_q <= hold_q.data;
          hold_q      <= '0;
          state_q     <= ST_IDLE;
        end
        default: begin
          reg_waddr_q <= ZeroReg;
          reg_we_q    <= WriteDisable;
          reg_wdata_q <= ZeroWord;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mc_ready_o  = mc_grant;
  assign stall_o     = force_grant;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_we_o    = reg_we_q;
  assign reg_wdata_o = reg_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios followed by random traffic.
module tb_wb_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk_i;
  logic        rst_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic        mc_valid_i;
  logic [4:0]  mc_waddr_i;
  logic [31:0] mc_wdata_i;
  logic        mc_ready_o;
  logic        stall_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .reg_waddr_i(reg_waddr_i),
    .reg_we_i   (reg_we_i),
    .reg_wdata_i(reg_wdata_i),
    .mc_valid_i (mc_valid_i),
    .mc_waddr_i (mc_waddr_i),
    .mc_wdata_i (mc_wdata_i),
    .mc_ready_o (mc_ready_o),
    .stall_o    (stall_o),
    .reg_waddr_o(reg_waddr_o),
    .reg_we_o   (reg_we_o),
    .reg_wdata_o(reg_wdata_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // Reference model state: how long the MC result has waited, and a pending replay
  int          mc_wait;
  bit          replay_pending;
  logic [4:0]  held_addr;
  logic [31:0] held_data;
  bit          last_stall;
  bit          last_ready;

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic mv, input logic [4:0] ma,
                       input logic [31:0] md);
    bit  e_ready;
    bit  e_stall;
    bit  pw;
    wr_t e;
    @(negedge clk_i);
    rst_i       = rst;
    reg_we_i    = we;
    reg_waddr_i = wa;
    reg_wdata_i = wd;
    mc_valid_i  = mv;
    mc_waddr_i  = ma;
    mc_wdata_i  = md;
    #1;
    e_ready = 1'b0;
    e_stall = 1'b0;
    e = '{we: 1'b0, addr: 5'd0, data: 32'd0};
    pw = we && (wa != 5'd0);
    if (!rst) begin
      mc_wait        = 0;
      replay_pending = 1'b0;
    end else if (replay_pending) begin
      e = '{we: (held_addr != 5'd0), addr: held_addr, data: held_data};
      replay_pending = 1'b0;
      mc_wait = mv ? ((mc_wait + 1 > int'(LIMIT)) ? int'(LIMIT) : mc_wait + 1) : 0;
    end else if (mv && (!pw || mc_wait >= int'(LIMIT))) begin
      e = '{we: (ma != 5'd0), addr: ma, data: md};
      e_ready = 1'b1;
      if (pw) begin
        e_stall        = 1'b1;
        replay_pending = 1'b1;
        held_addr      = wa;
        held_data      = wd;
      end
      mc_wait = 0;
    end else if (pw) begin
      e = '{we: 1'b1, addr: wa, data: wd};
      mc_wait = mv ? ((mc_wait + 1 > int'(LIMIT)) ? int'(LIMIT) : mc_wait + 1) : 0;
    end else begin
      mc_wait = 0;
    end
    checks++;
    if (mc_ready_o !== e_ready) begin
      errors++;
      $display("FAIL mc_ready t=%0t got=%b exp=%b", $time, mc_ready_o, e_ready);
    end
    checks++;
    if (stall_o !== e_stall) begin
      errors++;
      $display("FAIL stall t=%0t got=%b exp=%b", $time, stall_o, e_stall);
    end
    last_stall = e_stall;
    last_ready = e_ready;
    exp_q.push_back(e);
  endtask

  // Monitor: one regfile write slot per cycle, compared against the scoreboard
  initial begin
    wr_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (reg_we_o !== e.we || reg_waddr_o !== e.addr || reg_wdata_o !== e.data) begin
          errors++;
          $display("FAIL regwrite t=%0t got we=%b a=%0d d=%h exp we=%b a=%0d d=%h",
                   $time, reg_we_o, reg_waddr_o, reg_wdata_o, e.we, e.addr, e.data);
        end
        checks++;
        if (reg_we_o === 1'b1 && reg_waddr_o === 5'd0) begin
          errors++;
          $display("FAIL x0_write t=%0t got we=1 a=0 exp no write to x0", $time);
        end
      end
    end
  end

  initial begin
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        we;
    logic [4:0]  wa;
    rst_i = 1'b0; reg_we_i = 1'b0; reg_waddr_i = '0; reg_wdata_i = '0;
    mc_valid_i = 1'b0; mc_waddr_i = '0; mc_wdata_i = '0;
    mc_wait = 0; replay_pending = 1'b0; held_addr = '0; held_data = '0;
    last_stall = 1'b0; last_ready = 1'b0;

    // Reset with busy inputs: no handshakes, outputs zero
    drive(1'b0, 1'b1, 5'd4, 32'h1111, 1'b1, 5'd6, 32'h2222);
    drive(1'b0, 1'b1, 5'd4, 32'h1111, 1'b1, 5'd6, 32'h2222);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Pipeline write x5 with MC idle
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    // MC write x7 during a pipeline bubble
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Continuous contention: four pipeline writes, then forced grant and replay
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b1, 5'(10 + i), 32'(32'hA0 + i), 1'b1, 5'd9, 32'h99);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Same-address forced grant on x3: MC value first, pipeline value second
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b1, 5'd3, 32'h2, 1'b1, 5'd3, 32'h1);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Pipeline write to x0 does not block the MC
    drive(1'b1, 1'b1, 5'd0, 32'h5555, 1'b1, 5'd8, 32'h88);
    drive(1'b1, 1'b1, 5'd0, 32'h6666, 1'b0, 5'd0, 32'h0);

    // Reset landing on the forced-grant cycle discards the replay
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b1, 5'd12, 32'(32'hC0 + i), 1'b1, 5'd13, 32'hD0);
    drive(1'b0, 1'b1, 5'd12, 32'hC4, 1'b1, 5'd13, 32'hD0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Random traffic; the MC source holds its result until accepted
    mv = 1'b0; ma = 5'd1; md = 32'h0;
    for (int n = 0; n < 600; n++) begin
      logic r;
      if (!mv || last_ready) begin
        mv = ($urandom_range(0, 99) < 60);
        ma = 5'($urandom_range(1, 31));
        md = $urandom;
      end
      we = ($urandom_range(0, 99) < 75) && !last_stall;
      wa = 5'($urandom_range(0, 31));
      r  = ($urandom_range(0, 99) >= 2);
      drive(r, we, wa, $urandom, mv, ma, md);
      if (!r) mv = 1'b0;
    end

    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (3) @(posedge clk_i);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive ungranted multi-cycle-unit (MC) request cycles before a forced grant.
REQ-002 Ports (name, direction, width, meaning):
- clk_i, in, 1, sole clock.
- rst_i, in, 1, reset, synchronous, active-low (RstEnable = 1'b0).
- reg_waddr_i, in, RegAddrBus (5), pipeline writeback address from MEM/WB.
- reg_we_i, in, 1, pipeline writeback enable.
- reg_wdata_i, in, RegBus (32), pipeline writeback data.
- mc_valid_i, in, 1, MC result valid.
- mc_waddr_i, in, 5, MC destination register.
- mc_wdata_i, in, 32, MC result data.
- mc_ready_o, out, 1, MC result accepted this cycle (combinational).
- stall_o, out, 1, request to pipeline control to insert a MEM/WB bubble next cycle (combinational).
- reg_waddr_o, out, 5, regfile write address (registered).
- reg_we_o, out, 1, regfile write enable (registered).
- reg_wdata_o, out, 32, regfile write data (registered).

Function
REQ-003 pipe_wr = reg_we_i && reg_waddr_i != 0; mc_wr = mc_valid_i; writes to x0 never reach the regfile (reg_we_o = 0).
REQ-004 All regfile outputs are registered; one write per cycle; latency from grant to reg_*_o is 1 cycle.
REQ-005 FSM states: IDLE, REPLAY.
REQ-006 IDLE, pipe_wr = 1, starve_cnt < STARVE_LIMIT: pipeline write is forwarded; mc_ready_o = 0; stall_o = 0.
REQ-007 IDLE, pipe_wr = 0, mc_wr = 1: MC write is forwarded; mc_ready_o = 1.
REQ-008 IDLE, both idle: reg_we_o <= 0; reg_waddr_o and reg_wdata_o <= 0.
REQ-009 starve_cnt (3 bits minimum, saturating at STARVE_LIMIT) increments each cycle mc_valid_i = 1 and mc_ready_o = 0; clears on grant or when mc_valid_i = 0.
REQ-010 Forced grant: IDLE, pipe_wr = 1, mc_wr = 1, starve_cnt == STARVE_LIMIT -> MC write forwarded, mc_ready_o = 1, stall_o = 1, pipeline write captured in the hold register, next state REPLAY.
REQ-011 REPLAY: hold register is forwarded; mc_ready_o = 0; stall_o = 0; next state IDLE.
REQ-012 Protocol: reg_we_i is guaranteed 0 in the cycle after stall_o = 1; any pipeline input in REPLAY is ignored.
REQ-013 Same-address forced grant (mc_waddr_i == reg_waddr_i): MC value written first, pipeline value second; the final regfile content is the pipeline value.
REQ-014 mc_ready_o never asserts while mc_valid_i = 0.

Reset
REQ-015 On clk_i rising edge with rst_i = 0: reg_waddr_o = 0, reg_we_o = 0 (WriteDisable), reg_wdata_o = 0, state = IDLE, starve_cnt = 0, hold register cleared.
REQ-016 During reset, mc_ready_o = 0 and stall_o = 0; a pending REPLAY is discarded.

Structure
REQ-017 The constants RstEnable, WriteEnable/WriteDisable, ZeroReg, ZeroWord, RegBus, RegAddrBus and the FSM state encodings belong in the shared defines package.
REQ-018 Single module; no sub-modules; the hold register is a plain register set {addr, data}.

Verification
REQ-019 Pipeline write x5 = 0xDEADBEEF, MC idle -> next cycle reg_we_o = 1, reg_waddr_o = 5, reg_wdata_o = 0xDEADBEEF.
REQ-020 MC valid x7 = 0x12, pipeline bubble -> mc_ready_o = 1 in the same cycle; next cycle the regfile write is x7 = 0x12.
REQ-021 MC valid continuously and pipeline writing every cycle, STARVE_LIMIT = 4 -> 4 cycles of pipeline writes, then the forced grant: stall_o = 1, MC written, REPLAY writes the held pipeline value, starve_cnt = 0.
REQ-022 Forced grant where both target x3 (MC 0x1, pipeline 0x2) -> writes x3 = 0x1, then x3 = 0x2.
REQ-023 Pipeline write to x0 with MC valid -> MC granted; reg_we_o never 1 with reg_waddr_o = 0.
REQ-024 rst_i = 0 asserted in the forced-grant cycle -> next cycle all outputs are 0, state IDLE, with no REPLAY write.
